phy_rx_multilane: RTL and testbench
===================================

// Module: phy_rx_multilane
// PURPOSE
//  Parametrised receive PHY front end. It deserialises LANES serial bit streams and aligns each lane on a comma symbol.
//  Each lane assembles symbols into words and holds them in a per-lane deskew FIFO.
//  Words leave round-robin (unstriping) onto one word stream.
//  Single-clock successor of the two-lane multi-clock receive path; slow-rate timing is carried by valid, not by derived clocks.
// PARAMETERS
//  LANES        2      number of serial lanes (>=1)
//  SYM_W        8      bits per symbol
//  SYMS_PER_W   4      symbols per output word; WORD_W = SYM_W*SYMS_PER_W
//  COMMA        8'hBC  alignment/idle symbol (SYM_W bits)
//  LOCK_COUNT   4      consecutive aligned commas required for lock (>=1)
//  FIFO_DEPTH   4      per-lane deskew FIFO depth in words (power of 2, >=2)
// PORTS
//  clk_32f    in   1           bit clock; one serial bit per lane per cycle; all logic rising-edge
//  reset      in   1           synchronous, active-high; clears all state
//  data_in    in   LANES       serial input; bit i = lane i; MSB of each symbol first
//  data_out   out  WORD_W      unstriped word; first received symbol in the MSBs
//  valid_out  out  1           data_out valid this cycle
//  active     out  LANES       lane i locked
//  overflow   out  LANES       sticky; lane i dropped a word on a full FIFO
// BEHAVIOUR
//  Reset, synchronous:
//   - data_out=0, valid_out=0, active=0, overflow=0.
//   - All lane FSMs go to UNLOCKED; FIFOs are emptied; partial words are discarded; round-robin pointer rr=0.
//  Per lane, shift register sr:
//   - Every edge: sr <= {sr[SYM_W-2:0], data_in[i]}.
//   - Bit counter bc runs mod SYM_W. A symbol boundary is the edge where bc wraps to 0.
//  Lane FSM UNLOCKED:
//   - Compare the new sr value against COMMA every cycle (sliding).
//   - On a match: this edge becomes a boundary, bc <= 1, cnt <= 1.
//   - Next state is LOCKING, or LOCKED directly if LOCK_COUNT==1.
//  Lane FSM LOCKING, at each boundary:
//   - COMMA: cnt++. When cnt reaches LOCK_COUNT, go to LOCKED; active[i] rises on that same edge.
//   - Non-comma symbol: go to UNLOCKED with cnt=0; the symbol is discarded.
//  Lane FSM LOCKED:
//   - Held until reset; there is no loss-of-lock detection.
//   - At a boundary, a COMMA is idle and is skipped; a partial word is kept.
//   - A non-comma symbol is shifted into the word assembler.
//   - The SYMS_PER_W-th data symbol completes the word; it is written to the FIFO on the next edge.
//  FIFO write:
//   - If the FIFO is full, the word is dropped and overflow[i] is set until reset. FIFO contents are untouched.
//   - Words are accepted while other lanes are still unlocked; this is the deskew.
//  Unstriper, enabled only while &active:
//   - Each cycle, if FIFO[rr] is non-empty: pop it, data_out <= word, valid_out <= 1, rr <= (rr+1) mod LANES.
//   - Otherwise: valid_out <= 0, rr holds, data_out holds its last value.
//   - rr never skips a lane; output order is strictly lane0, lane1, ... , lane LANES-1, lane0, ...
//   - A simultaneous FIFO write and pop on a full FIFO is legal: the pop frees the slot, so there is no drop.
//  Latency:
//   - The final bit of a word is captured on edge k. The FIFO write happens on k+1.
//   - valid_out is high after edge k+2 at the earliest, when rr points at the lane and all lanes are active.
//  Throughput: at most 1 word per cycle out. Input aggregate is LANES words per SYM_W*SYMS_PER_W cycles, so there is no backpressure.
// TESTING
//  1 Assert reset 3 cycles with toggling data_in -> all outputs 0; FIFOs empty; valid_out 0 for 100 cycles with no commas.
//  2 Lane0: 5 junk bits, then 4x 8'hBC -> active[0] rises on the edge capturing the last bit of the 4th comma.
//    Lane0: 3x BC, then 8'h00, then BC -> active[0] stays 0.
//  3 Both lanes locked, lane1 skewed +2 symbols; lane0 sends DEADBEEF, lane1 sends 01234567
//    -> valid_out pulses: DEADBEEF, then 01234567; overflow=0.
//  4 Lane0 locked, lane1 idle unlocked; lane0 sends 5 words W0..W4 -> overflow[0]=1.
//    After lane1 locks and sends V0 -> output W0, V0, then W1.. per round-robin; W4 never appears.
//  5 Lane0 sends DE,BC,AD,BC,BC,BE,EF -> single word DEADBEEF; comma idles are transparent.
//  6 Reset mid-word with 2 words queued -> no valid_out after reset; active=0; relock required.
//    Rerun scenarios 3-5 with LANES=4, SYMS_PER_W=2, FIFO_DEPTH=8 and check order 0,1,2,3.

Source files
------------

// File: rtl/phy_rx_multilane_if.sv
// Receive-path bundle: serial lane inputs in, unstriped word stream and lane status out.
interface phy_rx_multilane_if #(
  parameter int LANES  = 2,
  parameter int WORD_W = 32
);
  logic [LANES-1:0]  data_in;
  logic [WORD_W-1:0] data_out;
  logic              valid_out;
  logic [LANES-1:0]  active;
  logic [LANES-1:0]  overflow;

  modport master (output data_in, input data_out, valid_out, active, overflow);
  modport slave  (input data_in, output data_out, valid_out, active, overflow);
endinterface

// File: rtl/phy_rx_multilane.sv
// Multilane receive front end: per-lane comma alignment, word assembly and deskew FIFO,
// followed by a strict round-robin unstriper onto one word stream.
module phy_rx_lane #(
  parameter int               SYM_W      = 8,
  parameter int               SYMS_PER_W = 4,
  parameter logic [SYM_W-1:0] COMMA      = 8'hBC,
  parameter int               LOCK_COUNT = 4,
  parameter int               FIFO_DEPTH = 4,
  localparam int              WORD_W     = SYM_W * SYMS_PER_W
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              din,
  input  logic              pop,
  output logic              active,
  output logic              overflow,
  output logic              empty,
  output logic [WORD_W-1:0] head
);
  localparam int BCW = $clog2(SYM_W);
  localparam int SCW = $clog2(SYMS_PER_W + 1);
  localparam int CW  = $clog2(LOCK_COUNT + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} st_t;
  st_t st, st_nxt;

  logic [SYM_W-2:0]  sr;
  logic [SYM_W-1:0]  sym;
  logic              match, bnd, take;
  logic [BCW-1:0]    bc;
  logic [CW-1:0]     cnt;
  logic [SCW-1:0]    sc;
  logic [WORD_W-1:0] wacc, wsh, wrd;
  logic              wr_pend;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wp, rp;
  logic [AW:0]       fcnt;
  logic              full, wr;

  // sym is the value sr takes on this edge; only its low SYM_W-1 bits need storing
  assign sym   = {sr, din};
  assign match = (sym == COMMA);
  assign bnd   = (bc == '0);
  assign wsh   = WORD_W'({wacc, sym});

  always_ff @(posedge clk_32f) begin
    if (reset) st <= UNLOCKED;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      UNLOCKED: if (match) st_nxt = (LOCK_COUNT == 1) ? LOCKED : LOCKING;
      LOCKING:  if (bnd) begin
                  if (!match)                        st_nxt = UNLOCKED;
                  else if (cnt == CW'(LOCK_COUNT-1)) st_nxt = LOCKED;
                end
      default:  st_nxt = st;
    endcase
  end

  always_comb begin
    active = (st == LOCKED);
    take   = (st == LOCKED) && bnd && !match;
  end

  // a sliding comma hit makes this edge a boundary, so the next boundary is SYM_W edges later
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      sr      <= '0;
      bc      <= '0;
      cnt     <= '0;
      sc      <= '0;
      wacc    <= '0;
      wrd     <= '0;
      wr_pend <= 1'b0;
    end else begin
      sr      <= sym[SYM_W-2:0];
      wr_pend <= 1'b0;
      if (st == UNLOCKED && match) begin
        bc  <= BCW'(1);
        cnt <= CW'(1);
      end else begin
        bc <= (bc == BCW'(SYM_W-1)) ? '0 : bc + 1'b1;
        if (st == LOCKING && bnd) cnt <= match ? cnt + 1'b1 : '0;
      end
      if (take) begin
        if (sc == SCW'(SYMS_PER_W-1)) begin
          sc      <= '0;
          wrd     <= wsh;
          wr_pend <= 1'b1;
        end else begin
          sc   <= sc + 1'b1;
          wacc <= wsh;
        end
      end
    end
  end

  // a pop in the same cycle frees the slot, so a full FIFO still accepts the word
  assign full  = (fcnt == (AW+1)'(FIFO_DEPTH));
  assign empty = (fcnt == '0);
  assign wr    = wr_pend && (!full || pop);
  assign head  = mem[rp];

  always_ff @(posedge clk_32f) begin
    if (wr) mem[wp] <= wrd;
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      wp       <= '0;
      rp       <= '0;
      fcnt     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fcnt <= fcnt + (AW+1)'(wr) - (AW+1)'(pop);
      if (wr_pend && !wr) overflow <= 1'b1;
    end
  end
endmodule

module phy_rx_multilane #(
  parameter int               LANES      = 2,
  parameter int               SYM_W      = 8,
  parameter int               SYMS_PER_W = 4,
  parameter logic [SYM_W-1:0] COMMA      = 8'hBC,
  parameter int               LOCK_COUNT = 4,
  parameter int               FIFO_DEPTH = 4,
  localparam int              WORD_W     = SYM_W * SYMS_PER_W
) (
  input  logic               clk_32f,
  input  logic               reset,
  phy_rx_multilane_if.slave  rx
);
  localparam int RW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES-1:0]             act, ovf, emp, pop;
  logic [LANES-1:0][WORD_W-1:0] head;
  logic [RW-1:0]                rr;
  logic                         en, go;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    phy_rx_lane #(
      .SYM_W(SYM_W), .SYMS_PER_W(SYMS_PER_W), .COMMA(COMMA),
      .LOCK_COUNT(LOCK_COUNT), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_lane (
      .clk_32f  (clk_32f),
      .reset    (reset),
      .din      (rx.data_in[i]),
      .pop      (pop[i]),
      .active   (act[i]),
      .overflow (ovf[i]),
      .empty    (emp[i]),
      .head     (head[i])
    );
  end

  assign rx.active   = act;
  assign rx.overflow = ovf;

  // rr waits on an empty lane rather than skipping it, which keeps the unstripe order exact
  assign en = &act;
  assign go = en && !emp[rr];

  always_comb begin
    pop     = '0;
    pop[rr] = go;
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      rr           <= '0;
      rx.data_out  <= '0;
      rx.valid_out <= 1'b0;
    end else begin
      rx.valid_out <= go;
      if (go) begin
        rx.data_out <= head[rr];
        rr          <= (rr == RW'(LANES-1)) ? '0 : rr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_phy_rx_multilane.sv
// Bench for phy_rx_multilane: a 2-lane/32-bit and a 4-lane/16-bit instance side by side,
// per-lane bit queues feed the serial inputs, scoreboards hold the expected word order.
module tb_phy_rx_multilane;
  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic [5:0] d       = '0;

  always #5 clk_32f = ~clk_32f;

  phy_rx_multilane_if #(.LANES(2), .WORD_W(32)) if2 ();
  phy_rx_multilane_if #(.LANES(4), .WORD_W(16)) if4 ();

  phy_rx_multilane u_dut2 (.clk_32f(clk_32f), .reset(reset), .rx(if2));
  phy_rx_multilane #(.LANES(4), .SYMS_PER_W(2), .FIFO_DEPTH(8))
    u_dut4 (.clk_32f(clk_32f), .reset(reset), .rx(if4));

  int          n_chk = 0, n_fail = 0;
  bit          lq [6][$];
  bit          idle_c [6];
  int          bits_sent [6];
  logic [31:0] sb2 [$];
  logic [15:0] sb4 [$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_sym(int l, logic [7:0] s);
    for (int b = 7; b >= 0; b--) lq[l].push_back(s[b]);
  endtask

  task automatic push_word(int l, logic [31:0] w, int ns);
    for (int s = ns - 1; s >= 0; s--) push_sym(l, w[s*8 +: 8]);
  endtask

  task automatic lock(int l);
    repeat (4) push_sym(l, 8'hBC);
    idle_c[l] = 1'b1;
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk_32f);
      #1;
    end
  endtask

  task automatic do_reset(bit toggle);
    @(negedge clk_32f);
    #1;
    reset = 1'b1;
    for (int l = 0; l < 6; l++) begin
      lq[l].delete();
      idle_c[l] = 1'b0;
      if (toggle) begin
        push_sym(l, 8'h55);
        push_sym(l, 8'h55);
      end
    end
    sb2.delete();
    sb4.delete();
    repeat (3) @(posedge clk_32f);
    @(negedge clk_32f);
    #1;
    reset = 1'b0;
  endtask

  task automatic watch(int n, output int vcnt, output logic [5:0] act_or);
    vcnt   = 0;
    act_or = '0;
    repeat (n) begin
      tick(1);
      vcnt   += int'(if2.valid_out) + int'(if4.valid_out);
      act_or |= {if4.active, if2.active};
    end
  endtask

  task automatic drain(string tag, int budget);
    int t = 0;
    while ((sb2.size() != 0 || sb4.size() != 0) && t < budget) begin
      tick(1);
      t++;
    end
    chk({tag, "_sb2_left"}, 32'(sb2.size()), 0);
    chk({tag, "_sb4_left"}, 32'(sb4.size()), 0);
    tick(60);
  endtask

  // serial driver: idle lanes send zeros, or whole commas once they are meant to stay locked
  initial forever begin
    @(negedge clk_32f);
    for (int l = 0; l < 6; l++) begin
      if (lq[l].size() == 0 && idle_c[l]) push_sym(l, 8'hBC);
      d[l] = (lq[l].size() != 0) ? lq[l].pop_front() : 1'b0;
      bits_sent[l]++;
    end
    if2.data_in = d[1:0];
    if4.data_in = d[5:2];
  end

  initial forever begin
    @(negedge clk_32f);
    if (if2.valid_out) begin
      if (sb2.size() == 0) chk("dut2_unexp_word", 32'(sb2.size()), 1);
      else                 chk("dut2_word", if2.data_out, sb2.pop_front());
    end
    if (if4.valid_out) begin
      if (sb4.size() == 0) chk("dut4_unexp_word", 32'(sb4.size()), 1);
      else                 chk("dut4_word", 32'(if4.data_out), 32'(sb4.pop_front()));
    end
  end

  initial begin
    int         vcnt, base, t;
    logic [5:0] act_or;

    // reset with toggling inputs, then a comma-free idle stretch
    do_reset(1'b1);
    chk("rst_dout2",  if2.data_out, 0);
    chk("rst_vld2",   32'(if2.valid_out), 0);
    chk("rst_act2",   32'(if2.active), 0);
    chk("rst_ovf2",   32'(if2.overflow), 0);
    chk("rst_dout4",  32'(if4.data_out), 0);
    chk("rst_vld4",   32'(if4.valid_out), 0);
    chk("rst_act4",   32'(if4.active), 0);
    chk("rst_ovf4",   32'(if4.overflow), 0);
    watch(100, vcnt, act_or);
    chk("idle_valid", 32'(vcnt), 0);
    chk("idle_active", 32'(act_or), 0);

    // lock timing: junk bits, then 4 commas; active rises on the 37th bit's edge
    do_reset(1'b0);
    lq[0].push_back(1'b1); lq[0].push_back(1'b0); lq[0].push_back(1'b1);
    lq[0].push_back(1'b1); lq[0].push_back(1'b0);
    lock(0);
    base = bits_sent[0];
    t = 0;
    while (bits_sent[0] < base + 37 && t < 100) begin
      tick(1);
      t++;
    end
    chk("lock_bits_reached", 32'(bits_sent[0] - base), 37);
    chk("act_before_last_bit", 32'(if2.active[0]), 0);
    @(posedge clk_32f);
    #1;
    chk("act_on_last_bit", 32'(if2.active[0]), 1);

    // a non-comma during LOCKING drops back to UNLOCKED
    do_reset(1'b0);
    repeat (3) push_sym(0, 8'hBC);
    push_sym(0, 8'h00);
    push_sym(0, 8'hBC);
    watch(80, vcnt, act_or);
    chk("broken_lock_act", 32'(act_or[0]), 0);

    // skewed lanes, one word each; order must follow lane index
    do_reset(1'b0);
    lock(0); push_word(0, 32'hDEADBEEF, 4);
    push_sym(1, 8'h00); push_sym(1, 8'h00);
    lock(1); push_word(1, 32'h01234567, 4);
    sb2.push_back(32'hDEADBEEF);
    sb2.push_back(32'h01234567);
    for (int k = 0; k < 4; k++) begin
      repeat (k) push_sym(2 + k, 8'h00);
      lock(2 + k);
      push_word(2 + k, 32'(16'h0102 * (k + 1)), 2);
      sb4.push_back(16'(16'h0102 * (k + 1)));
    end
    drain("skew", 400);
    chk("skew_ovf2", 32'(if2.overflow), 0);
    chk("skew_ovf4", 32'(if4.overflow), 0);

    // lane0 overruns its FIFO while the others are still unlocked
    do_reset(1'b0);
    lock(0);
    for (int n = 0; n < 5; n++) push_word(0, 32'h11111111 * (n + 1), 4);
    lock(2);
    for (int n = 0; n < 9; n++) push_word(2, 32'(16'h1111 * (n + 1)), 2);
    tick(300);
    chk("ovf_set2", 32'(if2.overflow), 32'h1);
    chk("ovf_set4", 32'(if4.overflow), 32'h1);
    chk("ovf_no_out_vld2", 32'(if2.valid_out), 0);
    lock(1);
    for (int n = 0; n < 3; n++) push_word(1, 32'hA0A0A0A0 + n, 4);
    for (int n = 0; n < 3; n++) begin
      sb2.push_back(32'h11111111 * (n + 1));
      sb2.push_back(32'hA0A0A0A0 + n);
    end
    sb2.push_back(32'h44444444);
    for (int k = 1; k < 4; k++) begin
      lock(2 + k);
      for (int j = 0; j < 2; j++) push_word(2 + k, {16'h0, 4'hA, 4'(k), 8'(j)}, 2);
    end
    for (int j = 0; j < 2; j++) begin
      sb4.push_back(16'(16'h1111 * (j + 1)));
      for (int k = 1; k < 4; k++) sb4.push_back({4'hA, 4'(k), 8'(j)});
    end
    sb4.push_back(16'h3333);
    drain("ovf", 600);
    chk("ovf_sticky2", 32'(if2.overflow), 32'h1);

    // comma idles inside a word are transparent
    do_reset(1'b0);
    lock(0);
    push_sym(0, 8'hDE); push_sym(0, 8'hBC); push_sym(0, 8'hAD); push_sym(0, 8'hBC);
    push_sym(0, 8'hBC); push_sym(0, 8'hBE); push_sym(0, 8'hEF);
    lock(1); push_word(1, 32'h11223344, 4);
    sb2.push_back(32'hDEADBEEF);
    sb2.push_back(32'h11223344);
    lock(2);
    push_sym(2, 8'hDE); push_sym(2, 8'hBC); push_sym(2, 8'hAD); push_sym(2, 8'hBC);
    push_sym(2, 8'hBC); push_sym(2, 8'hBE); push_sym(2, 8'hEF);
    for (int k = 1; k < 4; k++) begin
      lock(2 + k);
      for (int j = 0; j < 2; j++) push_word(2 + k, {16'h0, 8'(8'hC0 + k), 8'(8'h10 + j)}, 2);
    end
    for (int j = 0; j < 2; j++) begin
      sb4.push_back(j == 0 ? 16'hDEAD : 16'hBEEF);
      for (int k = 1; k < 4; k++) sb4.push_back({8'(8'hC0 + k), 8'(8'h10 + j)});
    end
    drain("idle", 400);

    // reset with two words queued and a half-built word; partial must not leak after relock
    do_reset(1'b0);
    lock(0);
    push_word(0, 32'h12345678, 4); push_word(0, 32'h9ABCDEF0, 4);
    push_sym(0, 8'hDE); push_sym(0, 8'hAD);
    lock(2);
    push_word(2, 32'h1234, 2); push_word(2, 32'h5678, 2);
    push_sym(2, 8'hDE);
    tick(130);
    do_reset(1'b0);
    watch(50, vcnt, act_or);
    chk("post_rst_valid", 32'(vcnt), 0);
    chk("post_rst_active", 32'(act_or), 0);
    lock(0); push_word(0, 32'hCAFE1234, 4);
    lock(1); push_word(1, 32'h5A5A5A5A, 4);
    sb2.push_back(32'hCAFE1234);
    sb2.push_back(32'h5A5A5A5A);
    for (int k = 0; k < 4; k++) begin
      lock(2 + k);
      push_word(2 + k, {16'h0, 8'hE0, 8'(k)}, 2);
      sb4.push_back({8'hE0, 8'(k)});
    end
    drain("relock", 400);
    chk("relock_act2", 32'(if2.active), 32'h3);
    chk("relock_act4", 32'(if4.active), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
